mem_access: RTL and testbench



---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_lsu_align.sv | 52 +++++
 rtl/mem_access.sv | 151 +++++++++++++++
 tb/tb_mem_access.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller: funct3 encodings,
// FSM state encoding, fault cause codes and access legality helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    // Loads reject 011/110/111; stores accept only the three plain widths.
    function automatic logic is_illegal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return f3[2] || (f3[1:0] == 2'b11);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads; purely combinational.
module mem_access_lsu_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_ext_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case ({1'b0, funct3_i[1:0]})
            F3_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            F3_SH: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            F3_SW: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
            default: ;
        endcase
    end

    // Only aligned accesses reach the bus, so shifting the addressed lane
    // down to bit 0 serves bytes, halves and words alike.
    always_comb begin
        shifted    = rdata_i >> {addr_lo_i, 3'b000};
        load_ext_o = 32'h0;
        case (funct3_i)
            F3_LB:   load_ext_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_ext_o = {24'h0, shifted[7:0]};
            F3_LH:   load_ext_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_ext_o = {16'h0, shifted[15:0]};
            F3_LW:   load_ext_o = shifted;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access controller: sequences each load/store as a
// handshaked bus transaction, stalls the pipeline and reports faults.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        ce,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] data_addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        ack
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        sdata_q, sdata_d;
    logic               is_load_q, is_load_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cause_q, cause_d;
    logic [31:0]        load_data_q, load_data_d;

    logic [3:0]         align_be;
    logic [31:0]        align_wdata;
    logic [31:0]        align_load;

    mem_access_lsu_align u_lsu_align (
        .funct3_i     (funct3_q),
        .addr_lo_i    (addr_q[1:0]),
        .store_data_i (sdata_q),
        .rdata_i      (rdata),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .load_ext_o   (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            funct3_q    <= 3'b000;
            sdata_q     <= 32'h0;
            is_load_q   <= 1'b0;
            cnt_q       <= '0;
            cause_q     <= CAUSE_NONE;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            sdata_q     <= sdata_d;
            is_load_q   <= is_load_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            load_data_q <= load_data_d;
        end
    end

    // Next-state and bus outputs; DONE/FAULT ignore the still-present request
    // so the same instruction is never accepted twice.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        sdata_d     = sdata_q;
        is_load_d   = is_load_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        load_data_d = load_data_q;
        stall       = 1'b0;
        load_valid  = 1'b0;
        fault       = 1'b0;
        fault_cause = CAUSE_NONE;
        ce          = 1'b0;
        we          = 1'b0;
        be          = 4'b0000;
        data_addr   = 32'h0;
        wdata       = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (read_mem || write_mem) begin
                    stall     = 1'b1;
                    addr_d    = result;
                    funct3_d  = funct3;
                    sdata_d   = store_data;
                    is_load_d = read_mem;
                    cnt_d     = '0;
                    if (is_illegal(read_mem, funct3)) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = ST_FAULT;
                    end else if (is_misaligned(funct3, result[1:0])) begin
                        cause_d = CAUSE_MISALIGN;
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall     = 1'b1;
                ce        = 1'b1;
                we        = ~is_load_q;
                be        = align_be;
                data_addr = {addr_q[31:2], 2'b00};
                wdata     = align_wdata;
                if (ack) begin
                    state_d = ST_DONE;
                    if (is_load_q) begin
                        load_data_d = align_load;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                load_valid = is_load_q;
                state_d    = ST_IDLE;
            end
            ST_FAULT: begin
                fault       = 1'b1;
                fault_cause = cause_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected load results are queued when a
// load is issued and popped when load_valid reports completion.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        read_mem;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] result;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        ce;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    int nCompared = 0;
    int nMismatch = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastLoad;

    int          obsDone;
    int          obsStallCycles;
    int          obsCeCycles;
    logic        obsStable;
    logic        obsWe;
    logic [3:0]  obsBe;
    logic [31:0] obsAddr;
    logic [31:0] obsWdata;
    logic        obsLv;
    logic        obsFault;
    logic [1:0]  obsCause;
    logic [31:0] obsLoad;

    mem_access #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_mem    (read_mem),
        .write_mem   (write_mem),
        .funct3      (funct3),
        .result      (result),
        .store_data  (store_data),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .fault       (fault),
        .fault_cause (fault_cause),
        .ce          (ce),
        .we          (we),
        .be          (be),
        .data_addr   (data_addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ack         (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sizeOf(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(a) && i < int'(a) + sizeOf(f3)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int n;
        n = sizeOf(f3);
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = sd[8*(i % n) +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
        logic [7:0]  bytes [4];
        logic [15:0] h;
        int idx;
        for (int i = 0; i < 4; i++) bytes[i] = rd[8*i +: 8];
        idx = int'(a);
        h = {bytes[(idx + 1) % 4], bytes[idx]};
        case (f3)
            3'b000:  return {{24{bytes[idx][7]}}, bytes[idx]};
            3'b100:  return {24'h0, bytes[idx]};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // Drives one request and follows it to its DONE/FAULT cycle, recording
    // what the bus and status outputs did along the way.
    task automatic applyStimulus(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sd, input logic [31:0] rd, input int waits);
        @(negedge clk);
        read_mem   = isLoad;
        write_mem  = ~isLoad;
        funct3     = f3;
        result     = addr;
        store_data = sd;
        ack        = 1'b0;
        rdata      = 32'h5A5A_A5A5;
        #1;
        obsStallCycles = stall ? 1 : 0;
        obsCeCycles = 0;
        obsDone   = -1;
        obsStable = 1'b1;
        obsWe = 1'b0; obsBe = 4'h0; obsAddr = 32'h0; obsWdata = 32'h0;
        obsLv = 1'b0; obsFault = 1'b0; obsCause = 2'b00; obsLoad = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #1;
            if (ce) begin
                if (obsCeCycles == 0) begin
                    obsWe = we; obsBe = be; obsAddr = data_addr; obsWdata = wdata;
                end else if (we !== obsWe || be !== obsBe || data_addr !== obsAddr || wdata !== obsWdata) begin
                    obsStable = 1'b0;
                end
                obsCeCycles++;
                ack   = (obsCeCycles > waits);
                rdata = ack ? rd : 32'h5A5A_A5A5;
            end else begin
                ack = 1'b0;
            end
            if (stall) begin
                obsStallCycles++;
            end else begin
                obsDone = k; obsLv = load_valid; obsFault = fault;
                obsCause = fault_cause; obsLoad = load_data;
                break;
            end
        end
        ack = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            read_mem = 1'b0; write_mem = 1'b0; ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nCompared++; if (stall !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
        nCompared++; if (ce !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_ce got %b want 0", ce); end
        nCompared++; if (load_valid !== 1'b0 || fault !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_pulses got lv=%b fault=%b want 0/0", load_valid, fault); end
        nCompared++; if (load_data !== 32'h0) begin nMismatch++; $display("[TB] FAIL reset_load_data got %h want 0", load_data); end
        nCompared++; if (be !== 4'h0 || data_addr !== 32'h0 || wdata !== 32'h0 || we !== 1'b0) begin
            nMismatch++; $display("[TB] FAIL reset_bus got be=%h addr=%h wdata=%h we=%b want all 0", be, data_addr, wdata, we); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [31:0] exp;
        expQ.push_back(32'hDEAD_BEEF);
        applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        nCompared++; if (obsDone !== 2) begin nMismatch++; $display("[TB] FAIL lw_latency got %0d want 2", obsDone); end
        nCompared++; if (obsStallCycles !== 2) begin nMismatch++; $display("[TB] FAIL lw_stall_cycles got %0d want 2", obsStallCycles); end
        nCompared++; if (obsAddr !== 32'h100 || obsBe !== 4'b1111 || obsWe !== 1'b0) begin
            nMismatch++; $display("[TB] FAIL lw_bus got addr=%h be=%b we=%b want 100/1111/0", obsAddr, obsBe, obsWe); end
        nCompared++; if (obsLv !== 1'b1) begin nMismatch++; $display("[TB] FAIL lw_valid got %b want 1", obsLv); end
        exp = expQ.pop_front();
        nCompared++; if (obsLoad !== exp) begin nMismatch++; $display("[TB] FAIL lw_data got %h want %h", obsLoad, exp); end
        lastLoad = exp;
    endtask

    task automatic test_byte_half_loads();
        logic [2:0]  f3Tab[4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adTab[4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rdTab[4] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_7F00, 32'h8001_7F00};
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(modelLoad(f3Tab[i], adTab[i][1:0], rdTab[i]));
            applyStimulus(1'b1, f3Tab[i], adTab[i], 32'h0, rdTab[i], 0);
            nCompared++; if (obsBe !== modelBe(f3Tab[i], adTab[i][1:0])) begin
                nMismatch++; $display("[TB] FAIL narrow_be[%0d] got %b want %b", i, obsBe, modelBe(f3Tab[i], adTab[i][1:0])); end
            nCompared++; if (obsLv !== 1'b1 || obsDone !== 2) begin
                nMismatch++; $display("[TB] FAIL narrow_done[%0d] got lv=%b cycle=%0d want 1/2", i, obsLv, obsDone); end
            exp = expQ.pop_front();
            nCompared++; if (obsLoad !== exp) begin nMismatch++; $display("[TB] FAIL narrow_data[%0d] got %h want %h", i, obsLoad, exp); end
            lastLoad = exp;
        end
    endtask

    task automatic test_store_waits();
        idleCycles(2);
        applyStimulus(1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3);
        nCompared++; if (obsWe !== 1'b1 || obsBe !== 4'b1100) begin
            nMismatch++; $display("[TB] FAIL sh_we_be got we=%b be=%b want 1/1100", obsWe, obsBe); end
        nCompared++; if (obsWdata !== 32'hABCD_ABCD || obsAddr !== 32'h200) begin
            nMismatch++; $display("[TB] FAIL sh_data_addr got wdata=%h addr=%h want abcdabcd/200", obsWdata, obsAddr); end
        nCompared++; if (obsDone !== 5 || obsCeCycles !== 4) begin
            nMismatch++; $display("[TB] FAIL sh_latency got done=%0d ce=%0d want 5/4", obsDone, obsCeCycles); end
        nCompared++; if (obsLv !== 1'b0 || obsFault !== 1'b0) begin
            nMismatch++; $display("[TB] FAIL sh_no_pulse got lv=%b fault=%b want 0/0", obsLv, obsFault); end
        nCompared++; if (obsStable !== 1'b1) begin nMismatch++; $display("[TB] FAIL sh_bus_stable got %b want 1", obsStable); end
        nCompared++; if (obsLoad !== lastLoad) begin nMismatch++; $display("[TB] FAIL load_data_hold got %h want %h", obsLoad, lastLoad); end
    endtask

    task automatic test_faults();
        logic        ldTab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3Tab[5] = '{3'b010, 3'b011, 3'b111, 3'b010, 3'b100};
        logic [31:0] adTab[5] = '{32'h101, 32'h100, 32'h103, 32'h102, 32'h100};
        logic [1:0]  cTab[5]  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ldTab[i], f3Tab[i], adTab[i], 32'hFFFF_FFFF, 32'h0, 0);
            nCompared++; if (obsFault !== 1'b1 || obsCause !== cTab[i]) begin
                nMismatch++; $display("[TB] FAIL fault_cause[%0d] got fault=%b cause=%b want 1/%b", i, obsFault, obsCause, cTab[i]); end
            nCompared++; if (obsCeCycles !== 0 || obsDone !== 1 || obsLv !== 1'b0) begin
                nMismatch++; $display("[TB] FAIL fault_no_access[%0d] got ce=%0d done=%0d lv=%b want 0/1/0", i, obsCeCycles, obsDone, obsLv); end
        end
    endtask

    task automatic test_timeout();
        idleCycles(1);
        applyStimulus(1'b0, 3'b010, 32'h300, 32'h0BAD_CAFE, 32'h0, 100);
        nCompared++; if (obsCeCycles !== 16 || obsDone !== 17) begin
            nMismatch++; $display("[TB] FAIL timeout_len got ce=%0d done=%0d want 16/17", obsCeCycles, obsDone); end
        nCompared++; if (obsFault !== 1'b1 || obsCause !== 2'b11) begin
            nMismatch++; $display("[TB] FAIL timeout_cause got fault=%b cause=%b want 1/11", obsFault, obsCause); end
        applyStimulus(1'b0, 3'b010, 32'h304, 32'h0BAD_CAFE, 32'h0, 15);
        nCompared++; if (obsFault !== 1'b0 || obsCeCycles !== 16 || obsDone !== 17) begin
            nMismatch++; $display("[TB] FAIL late_ack got fault=%b ce=%0d done=%0d want 0/16/17", obsFault, obsCeCycles, obsDone); end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] exp;
        idleCycles(1);
        @(negedge clk);
        read_mem = 1'b1; write_mem = 1'b0; funct3 = 3'b010; result = 32'h400; ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nCompared++; if (ce !== 1'b1) begin nMismatch++; $display("[TB] FAIL midreq_ce got %b want 1", ce); end
        rst_n = 1'b0; read_mem = 1'b0;
        #1;
        nCompared++; if (ce !== 1'b0 || stall !== 1'b0) begin
            nMismatch++; $display("[TB] FAIL midreq_abort got ce=%b stall=%b want 0/0", ce, stall); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nCompared++; if (fault !== 1'b0 || load_valid !== 1'b0 || load_data !== 32'h0) begin
            nMismatch++; $display("[TB] FAIL midreq_quiet got fault=%b lv=%b data=%h want 0/0/0", fault, load_valid, load_data); end
        expQ.push_back(32'h0BAD_F00D);
        applyStimulus(1'b1, 3'b010, 32'h404, 32'h0, 32'h0BAD_F00D, 0);
        exp = expQ.pop_front();
        nCompared++; if (obsLv !== 1'b1 || obsDone !== 2 || obsLoad !== exp) begin
            nMismatch++; $display("[TB] FAIL post_reset_lw got lv=%b done=%0d data=%h want 1/2/%h", obsLv, obsDone, obsLoad, exp); end
        lastLoad = exp;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ldF3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic        isLoad;
        logic [31:0] addr, sd, rd, exp;
        int          waits;
        for (int i = 0; i < 10; i++) begin
            isLoad = 1'($urandom_range(0, 1));
            f3     = isLoad ? ldF3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            addr   = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            if (sizeOf(f3) == 1) addr[1:0] = 2'($urandom_range(0, 3));
            if (sizeOf(f3) == 2) addr[1]   = 1'($urandom_range(0, 1));
            sd     = $urandom;
            rd     = $urandom;
            waits  = $urandom_range(0, 2);
            if (isLoad) expQ.push_back(modelLoad(f3, addr[1:0], rd));
            applyStimulus(isLoad, f3, addr, sd, rd, waits);
            nCompared++; if (obsDone !== 2 + waits || obsBe !== modelBe(f3, addr[1:0]) || obsAddr !== {addr[31:2], 2'b00}) begin
                nMismatch++; $display("[TB] FAIL b2b_bus[%0d] got done=%0d be=%b addr=%h want %0d/%b/%h",
                                      i, obsDone, obsBe, obsAddr, 2 + waits, modelBe(f3, addr[1:0]), {addr[31:2], 2'b00}); end
            if (isLoad) begin
                exp = expQ.pop_front();
                nCompared++; if (obsLv !== 1'b1 || obsLoad !== exp) begin
                    nMismatch++; $display("[TB] FAIL b2b_load[%0d] got lv=%b data=%h want 1/%h", i, obsLv, obsLoad, exp); end
            end else begin
                nCompared++; if (obsLv !== 1'b0 || obsWe !== 1'b1 || obsWdata !== modelWdata(f3, sd)) begin
                    nMismatch++; $display("[TB] FAIL b2b_store[%0d] got lv=%b we=%b wdata=%h want 0/1/%h", i, obsLv, obsWe, obsWdata, modelWdata(f3, sd)); end
            end
        end
        idleCycles(2);
    endtask

    initial begin
        rst_n = 1'b0; read_mem = 1'b0; write_mem = 1'b0; funct3 = 3'b000;
        result = 32'h0; store_data = 32'h0; rdata = 32'h0; ack = 1'b0;
        lastLoad = 32'h0;
        test_reset();
        test_lw();
        test_byte_half_loads();
        test_store_waits();
        test_faults();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
